// File: rtl/mem_map_pkg.sv
// Memory map, access classes and FSM state encoding shared by the
// memory access sequencer and its address decoder.
package mem_map_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      RD          = 3'd1,
      WR_SETUP    = 3'd2,
      WR_STROBE   = 3'd3,
      UART_WAIT   = 3'd4,
      UART_STROBE = 3'd5,
      ERR         = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      RAM2_RD = 3'd0,
      RAM2_WR = 3'd1,
      RAM1_RD = 3'd2,
      RAM1_WR = 3'd3,
      UART_RD = 3'd4,
      UART_WR = 3'd5,
      STAT_RD = 3'd6,
      ILLEGAL = 3'd7
   } access_e;

   // Writes below SYS_CODE_END would overwrite system code.
   localparam logic [15:0] SYS_CODE_END       = 16'h4000;
   // RAM2 holds 0x0000-0x7FFF, RAM1 holds 0x8000-0xFFFF.
   localparam logic [15:0] RAM1_BASE          = 16'h8000;
   localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
   localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;
   localparam int          TIMEOUT_DEF        = 255;
   localparam int          CNT_W              = 8;

   // Accesses that land on RAM2, which shares its bus with instruction fetch.
   function automatic logic is_ram2(access_e cls);
      return (cls == RAM2_RD) || (cls == RAM2_WR);
   endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Classifies the MEM-stage address and direction into an access class.
module mem_region_decode
   import mem_map_pkg::*;
#(
   parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF
) (
   input  logic        mem_rd_i,
   input  logic        mem_wr_i,
   input  logic [15:0] mem_addr_i,
   output logic [2:0]  cls_o
);

   localparam logic [15:0] UART_STAT_ADDR = UART_DATA_ADDR + 16'd1;

   access_e cls;

   // Priority: conflicting request, UART registers, then RAM regions.
   always_comb begin
      cls = ILLEGAL;
      if (mem_rd_i && mem_wr_i) begin
         cls = ILLEGAL;
      end else if (mem_addr_i == UART_DATA_ADDR) begin
         cls = mem_rd_i ? UART_RD : UART_WR;
      end else if (mem_addr_i == UART_STAT_ADDR) begin
         cls = mem_rd_i ? STAT_RD : ILLEGAL;
      end else if (mem_addr_i < RAM1_BASE) begin
         if (mem_rd_i)
            cls = RAM2_RD;
         else
            cls = (mem_addr_i < SYS_CODE_END) ? ILLEGAL : RAM2_WR;
      end else begin
         cls = mem_rd_i ? RAM1_RD : RAM1_WR;
      end
   end

   assign cls_o = cls;

endmodule

// File: rtl/mem_access_seq.sv
// MEM-stage access sequencer: drives RAM1/RAM2 and UART strobes, stalls the
// pipeline while an access is in flight and reports completion/errors.
// All strobes decode registered state only, so reset clears them at once.
module mem_access_seq
   import mem_map_pkg::*;
#(
   parameter int          TIMEOUT        = TIMEOUT_DEF,
   parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [15:0] mem_addr,
   input  logic        tbre,
   input  logic        tsre,
   input  logic        data_ready,
   output logic        sel_data,
   output logic        ram_oe_n,
   output logic        ram_we_n,
   output logic        ram_sel,
   output logic        uart_rdn,
   output logic        uart_wrn,
   output logic        mem_stall,
   output logic        if_stall,
   output logic        mem_done,
   output logic        mem_err
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   access_e          cls_q, cls_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       cls_raw;
   access_e          cls_dec;
   logic             uart_ready;

   mem_region_decode #(
      .UART_DATA_ADDR(UART_DATA_ADDR)
   ) u_decode (
      .mem_rd_i  (mem_rd),
      .mem_wr_i  (mem_wr),
      .mem_addr_i(mem_addr),
      .cls_o     (cls_raw)
   );

   assign cls_dec = access_e'(cls_raw);

   // The transmitter needs both holding and shift registers empty; receive
   // only needs a byte waiting.
   assign uart_ready = (cls_q == UART_WR) ? (tbre & tsre) : data_ready;

   // State, latched access class and UART wait counter.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cls_q   <= RAM2_RD;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: the class is captured once in IDLE so a request dropped
   // mid-access still runs its sequence to completion.
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (mem_rd || mem_wr) begin
               cls_d = cls_dec;
               case (cls_dec)
                  RAM2_RD, RAM1_RD, STAT_RD: state_d = RD;
                  RAM2_WR, RAM1_WR:          state_d = WR_SETUP;
                  UART_RD, UART_WR:          state_d = UART_WAIT;
                  default:                   state_d = ERR;
               endcase
            end
         end
         RD:          state_d = IDLE;
         WR_SETUP:    state_d = WR_STROBE;
         WR_STROBE:   state_d = IDLE;
         UART_WAIT: begin
            if (uart_ready)
               state_d = UART_STROBE;
            else if (cnt_q == CNT_LAST)
               state_d = ERR;
            else
               cnt_d = cnt_q + 1'b1;
         end
         UART_STROBE: state_d = IDLE;
         ERR:         state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   // Output decode from registered state and class only.
   always_comb begin
      sel_data = 1'b0;
      ram_oe_n = 1'b1;
      ram_we_n = 1'b1;
      ram_sel  = 1'b0;
      uart_rdn = 1'b1;
      uart_wrn = 1'b1;
      mem_done = 1'b0;
      mem_err  = 1'b0;
      case (state_q)
         RD: begin
            ram_sel  = ~is_ram2(cls_q);
            sel_data = is_ram2(cls_q);
            // Status reads come from the UART mux, not from RAM.
            ram_oe_n = (cls_q == STAT_RD);
            mem_done = 1'b1;
         end
         WR_SETUP: begin
            ram_sel  = ~is_ram2(cls_q);
            sel_data = is_ram2(cls_q);
         end
         WR_STROBE: begin
            ram_sel  = ~is_ram2(cls_q);
            sel_data = is_ram2(cls_q);
            ram_we_n = 1'b0;
            mem_done = 1'b1;
         end
         UART_WAIT: begin
            ram_sel = 1'b1;
         end
         UART_STROBE: begin
            ram_sel  = 1'b1;
            uart_wrn = (cls_q != UART_WR);
            uart_rdn = (cls_q != UART_RD);
            mem_done = 1'b1;
         end
         ERR: begin
            mem_done = 1'b1;
            mem_err  = 1'b1;
         end
         default: ;
      endcase
   end

   // Stalls release in the completion cycle so the pipeline advances on it.
   assign mem_stall = (mem_rd | mem_wr) & ~mem_done;
   assign if_stall  = mem_stall | sel_data;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: expected output vectors are queued per
// transaction and popped one per cycle as the DUT produces them.
module tb_mem_access_seq;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        mem_rd = 1'b0;
   logic        mem_wr = 1'b0;
   logic [15:0] mem_addr = 16'h0000;
   logic        tbre = 1'b0;
   logic        tsre = 1'b0;
   logic        data_ready = 1'b0;

   logic sel_data, ram_oe_n, ram_we_n, ram_sel, uart_rdn, uart_wrn;
   logic mem_stall, if_stall, mem_done, mem_err;
   logic sel_data4, ram_oe_n4, ram_we_n4, ram_sel4, uart_rdn4, uart_wrn4;
   logic mem_stall4, if_stall4, mem_done4, mem_err4;

   always #5 CLK = ~CLK;

   mem_access_seq dut (
      .CLK(CLK), .RST(RST), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .tbre(tbre), .tsre(tsre), .data_ready(data_ready),
      .sel_data(sel_data), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_sel(ram_sel),
      .uart_rdn(uart_rdn), .uart_wrn(uart_wrn), .mem_stall(mem_stall), .if_stall(if_stall),
      .mem_done(mem_done), .mem_err(mem_err)
   );

   mem_access_seq #(.TIMEOUT(4)) dut_t4 (
      .CLK(CLK), .RST(RST), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .tbre(tbre), .tsre(tsre), .data_ready(data_ready),
      .sel_data(sel_data4), .ram_oe_n(ram_oe_n4), .ram_we_n(ram_we_n4), .ram_sel(ram_sel4),
      .uart_rdn(uart_rdn4), .uart_wrn(uart_wrn4), .mem_stall(mem_stall4), .if_stall(if_stall4),
      .mem_done(mem_done4), .mem_err(mem_err4)
   );

   // {sel_data, ram_oe_n, ram_we_n, ram_sel, uart_rdn, uart_wrn, mem_stall, if_stall, mem_done, mem_err}
   wire [9:0] vec  = {sel_data, ram_oe_n, ram_we_n, ram_sel, uart_rdn, uart_wrn,
                      mem_stall, if_stall, mem_done, mem_err};
   wire [9:0] vec4 = {sel_data4, ram_oe_n4, ram_we_n4, ram_sel4, uart_rdn4, uart_wrn4,
                      mem_stall4, if_stall4, mem_done4, mem_err4};

   typedef struct {
      string      tag;
      logic [9:0] v;
      bit         t4;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [9:0] ov(bit sel, bit oe, bit we, bit rs, bit rdn, bit wrn,
                                     bit st, bit ifs, bit dn, bit er);
      return {sel, oe, we, rs, rdn, wrn, st, ifs, dn, er};
   endfunction

   localparam logic [9:0] IDLE_Q   = 10'b0_1_1_0_1_1_0_0_0_0;
   localparam logic [9:0] IDLE_REQ = 10'b0_1_1_0_1_1_1_1_0_0;
   localparam logic [9:0] ERR_V    = 10'b0_1_1_0_1_1_0_0_1_1;
   localparam logic [9:0] UWAIT_V  = 10'b0_1_1_1_1_1_1_1_0_0;

   task automatic push(input string tag, input logic [9:0] v, input bit t4 = 1'b0);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      e.t4  = t4;
      exp_q.push_back(e);
   endtask

   task automatic check_now();
      exp_t       e;
      logic [9:0] obs;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: got nothing queued required one entry");
      end else begin
         e   = exp_q.pop_front();
         obs = e.t4 ? vec4 : vec;
         assert (obs === e.v)
         else begin
            errors++;
            $error("FAIL %s: got %b required %b", e.tag, obs, e.v);
         end
      end
   endtask

   // Check the current cycle away from the edge, then step to just after the next edge.
   task automatic cyc();
      @(negedge CLK);
      check_now();
      @(posedge CLK);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic req(input bit rd, input bit wr, input logic [15:0] a);
      mem_rd   = rd;
      mem_wr   = wr;
      mem_addr = a;
   endtask

   task automatic drop_and_idle(input string tag);
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      push(tag, IDLE_Q);
      cyc();
   endtask

   task automatic reset_pulse();
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   initial begin
      // Reset state on both instances.
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      push("reset_state", IDLE_Q);
      check_now();
      push("reset_state_t4", IDLE_Q, 1'b1);
      check_now();
      @(posedge CLK);
      #1;
      RST = 1'b0;

      // RAM2 read: fetch blocked for the read cycle, done in cycle 2.
      req(1, 0, 16'h4010);
      push("rd4010_idle", IDLE_REQ);
      push("rd4010_rd", ov(1, 0, 1, 0, 1, 1, 0, 1, 1, 0));
      run(2);
      drop_and_idle("rd4010_back_idle");

      // RAM1 write: setup then strobe, fetch free.
      req(0, 1, 16'h9000);
      push("wr9000_idle", IDLE_REQ);
      push("wr9000_setup", ov(0, 1, 1, 1, 1, 1, 1, 1, 0, 0));
      push("wr9000_strobe", ov(0, 1, 0, 1, 1, 1, 0, 0, 1, 0));
      run(3);
      drop_and_idle("wr9000_back_idle");

      // System-code write is rejected.
      req(0, 1, 16'h1234);
      push("wr1234_idle", IDLE_REQ);
      push("wr1234_err", ERR_V);
      run(2);
      drop_and_idle("wr1234_back_idle");

      // Lowest writable RAM2 address.
      req(0, 1, 16'h4000);
      push("wr4000_idle", IDLE_REQ);
      push("wr4000_setup", ov(1, 1, 1, 0, 1, 1, 1, 1, 0, 0));
      push("wr4000_strobe", ov(1, 1, 0, 0, 1, 1, 0, 1, 1, 0));
      run(3);
      drop_and_idle("wr4000_back_idle");

      // Highest system-code address.
      req(0, 1, 16'h3FFF);
      push("wr3fff_idle", IDLE_REQ);
      push("wr3fff_err", ERR_V);
      run(2);
      drop_and_idle("wr3fff_back_idle");

      // First RAM1 address read.
      req(1, 0, 16'h8000);
      push("rd8000_idle", IDLE_REQ);
      push("rd8000_rd", ov(0, 0, 1, 1, 1, 1, 0, 0, 1, 0));
      run(2);
      drop_and_idle("rd8000_back_idle");

      // Read and write together.
      req(1, 1, 16'h5000);
      push("rdwr_idle", IDLE_REQ);
      push("rdwr_err", ERR_V);
      run(2);
      drop_and_idle("rdwr_back_idle");

      // UART status read: RD without RAM output enable.
      req(1, 0, 16'hBF01);
      push("stat_rd_idle", IDLE_REQ);
      push("stat_rd_rd", ov(0, 1, 1, 1, 1, 1, 0, 0, 1, 0));
      run(2);
      drop_and_idle("stat_rd_back_idle");

      // Write to the status register is illegal.
      req(0, 1, 16'hBF01);
      push("stat_wr_idle", IDLE_REQ);
      push("stat_wr_err", ERR_V);
      run(2);
      drop_and_idle("stat_wr_back_idle");

      // UART read already ready: minimum three cycles.
      data_ready = 1'b1;
      req(1, 0, 16'hBF00);
      push("urd_fast_idle", IDLE_REQ);
      push("urd_fast_wait", UWAIT_V);
      push("urd_fast_strobe", ov(0, 1, 1, 1, 0, 1, 0, 0, 1, 0));
      run(3);
      data_ready = 1'b0;
      drop_and_idle("urd_fast_back_idle");

      // UART write waits on tbre; strobe one cycle after it rises.
      tsre = 1'b1;
      tbre = 1'b0;
      req(0, 1, 16'hBF00);
      push("uwr_idle", IDLE_REQ);
      for (int i = 0; i < 5; i++) push($sformatf("uwr_wait%0d", i), UWAIT_V);
      run(6);
      tbre = 1'b1;
      push("uwr_wait_ready", UWAIT_V);
      push("uwr_strobe", ov(0, 1, 1, 1, 1, 0, 0, 0, 1, 0));
      run(2);
      tbre = 1'b0;
      tsre = 1'b0;
      drop_and_idle("uwr_strobe_released");

      // UART read timeout on the TIMEOUT=4 instance; request sampled right after reset.
      reset_pulse();
      req(1, 0, 16'hBF00);
      push("urd_to_idle", IDLE_REQ, 1'b1);
      for (int i = 0; i < 4; i++) push($sformatf("urd_to_wait%0d", i), UWAIT_V, 1'b1);
      push("urd_to_err", ERR_V, 1'b1);
      run(6);
      mem_rd = 1'b0;
      push("urd_to_back_idle", IDLE_Q, 1'b1);
      cyc();

      // Reset during WR_STROBE drops the strobe immediately.
      reset_pulse();
      req(0, 1, 16'h9000);
      push("rst_wr_idle", IDLE_REQ);
      push("rst_wr_setup", ov(0, 1, 1, 1, 1, 1, 1, 1, 0, 0));
      run(2);
      @(negedge CLK);
      push("rst_wr_strobe", ov(0, 1, 0, 1, 1, 1, 0, 0, 1, 0));
      check_now();
      #2;
      RST = 1'b1;
      #1;
      push("rst_wr_async", IDLE_REQ);
      check_now();
      mem_wr = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      push("rst_wr_after0", IDLE_Q);
      push("rst_wr_after1", IDLE_Q);
      run(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
